spawn_path_mc: RTL

//  Multi-channel successor to the single-object spawner: moves up to NCHAN sprites from a per-spawn

---
 rtl/spawn_path_mc_if.sv | 38 +++
 rtl/spawn_path_mc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spawn_path_mc_if.sv
// ----------------------------------------------------------------------------
// spawn_path_mc_if
// Shared spawn bus between the game controller (master) and the multi-channel
// sprite path generator (slave). One spawn request per cycle; it is taken on
// a cycle where spawn_valid and spawn_ready are both high.
//
// Signals
//   spawn_valid  master -> slave   request valid
//   spawn_ready  slave  -> master  request accepted this cycle when valid&ready
//   spawn_ch     master -> slave   target channel
//   src_h/src_v  master -> slave   signed start position
//   dst_h/dst_v  master -> slave   signed end position
// ----------------------------------------------------------------------------
interface spawn_path_mc_if #(
   parameter int HWIDTH = 11,
   parameter int VWIDTH = 10,
   parameter int NCHAN  = 4
);
   localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

   logic                     spawn_valid;
   logic                     spawn_ready;
   logic [CHW-1:0]           spawn_ch;
   logic signed [HWIDTH-1:0] src_h;
   logic signed [VWIDTH-1:0] src_v;
   logic signed [HWIDTH-1:0] dst_h;
   logic signed [VWIDTH-1:0] dst_v;

   modport master (
      output spawn_valid, spawn_ch, src_h, src_v, dst_h, dst_v,
      input  spawn_ready
   );

   modport slave (
      input  spawn_valid, spawn_ch, src_h, src_v, dst_h, dst_v,
      output spawn_ready
   );
endinterface

// File: rtl/spawn_path_mc.sv
// ----------------------------------------------------------------------------
// spawn_path_mc
// Moves up to NCHAN sprites, each from its own source to its own destination,
// in exactly STEPS frame ticks. The position after k ticks is
//    src + trunc0((dst - src) * k / STEPS)
// produced without a runtime divider: |delta| is split once at spawn time into
// quotient/remainder by the constant STEPS, and every tick adds both into a
// per-channel accumulator, carrying into the quotient when the remainder wraps.
//
// Ports
//   clk       in   system clock, all state on the rising edge
//   rst_n     in   asynchronous active-low reset
//   tick      in   one-cycle frame-advance pulse
//   spawn     if   spawn bus (slave side), see spawn_path_mc_if
//   abort     in   per-channel immediate return to idle
//   hoffset   out  channel i at [i*HWIDTH +: HWIDTH], signed
//   voffset   out  channel i at [i*VWIDTH +: VWIDTH], signed
//   active    out  channel moving or holding at its destination
//   done      out  one-cycle pulse when a channel lands on its destination
// ----------------------------------------------------------------------------
module spawn_path_mc #(
   parameter int HWIDTH      = 11,
   parameter int VWIDTH      = 10,
   parameter int NCHAN       = 4,
   parameter int STEPS       = 64,
   parameter int OFFSCREEN_H = 1000,
   parameter int OFFSCREEN_V = 1000,
   parameter int RETRIGGER   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick,
   spawn_path_mc_if.slave           spawn,
   input  logic [NCHAN-1:0]         abort,
   output logic [NCHAN*HWIDTH-1:0]  hoffset,
   output logic [NCHAN*VWIDTH-1:0]  voffset,
   output logic [NCHAN-1:0]         active,
   output logic [NCHAN-1:0]         done
);

   localparam int CHW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int KW  = $clog2(STEPS + 1);
   // Remainder accumulator must hold r + dr, which stays below 2*STEPS.
   localparam int RW  = $clog2(2 * STEPS + 1);

   localparam logic [HWIDTH-1:0] OFF_H   = HWIDTH'(OFFSCREEN_H);
   localparam logic [VWIDTH-1:0] OFF_V   = VWIDTH'(OFFSCREEN_V);
   localparam logic [RW-1:0]     STEPS_R = RW'(STEPS);
   localparam logic [31:0]       STEPS_W = 32'(STEPS);
   localparam logic [KW-1:0]     LAST_K  = KW'(STEPS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MOVE,
      ST_HOLD
   } state_t;

   logic [NCHAN-1:0] ch_ready;
   logic [NCHAN-1:0] accept;

   // The spawn bus is shared, so the ready seen by the controller is the
   // readiness of whichever channel it is currently addressing. A channel
   // number that matches no channel stays refused.
   always_comb begin
      spawn.spawn_ready = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         if (spawn.spawn_ch == CHW'(i)) spawn.spawn_ready = ch_ready[i];
      end
   end

   // Spawn-time split of the path into sign, |delta| / STEPS and
   // |delta| % STEPS. Only one spawn can be taken per cycle, so a single
   // copy serves every channel. delta needs one extra bit; |delta| never
   // exceeds 2^HWIDTH-1, so its low HWIDTH bits are enough.
   logic [HWIDTH:0]   delta_h;
   logic [VWIDTH:0]   delta_v;
   logic              neg_h, neg_v;
   logic [HWIDTH-1:0] abs_h, dq_h;
   logic [VWIDTH-1:0] abs_v, dq_v;
   logic [RW-1:0]     dr_h, dr_v;

   always_comb begin
      delta_h = {spawn.dst_h[HWIDTH-1], spawn.dst_h} - {spawn.src_h[HWIDTH-1], spawn.src_h};
      delta_v = {spawn.dst_v[VWIDTH-1], spawn.dst_v} - {spawn.src_v[VWIDTH-1], spawn.src_v};
      neg_h   = delta_h[HWIDTH];
      neg_v   = delta_v[VWIDTH];
      abs_h   = neg_h ? (~delta_h[HWIDTH-1:0]) + HWIDTH'(1) : delta_h[HWIDTH-1:0];
      abs_v   = neg_v ? (~delta_v[VWIDTH-1:0]) + VWIDTH'(1) : delta_v[VWIDTH-1:0];
      dq_h    = HWIDTH'(32'(abs_h) / STEPS_W);
      dr_h    = RW'(32'(abs_h) % STEPS_W);
      dq_v    = VWIDTH'(32'(abs_v) / STEPS_W);
      dr_v    = RW'(32'(abs_v) % STEPS_W);
   end

   for (genvar i = 0; i < NCHAN; i++) begin : g_ch
      state_t            state_q;
      logic [KW-1:0]     k_q;
      logic [HWIDTH-1:0] src_h_q, dq_h_q, q_h_q, off_h_q, q_h_n, pos_h_n;
      logic [VWIDTH-1:0] src_v_q, dq_v_q, q_v_q, off_v_q, q_v_n, pos_v_n;
      logic [RW-1:0]     dr_h_q, r_h_q, sum_h, r_h_n;
      logic [RW-1:0]     dr_v_q, r_v_q, sum_v, r_v_n;
      logic              neg_h_q, neg_v_q, active_q, done_q;

      // Abort on the addressed channel blocks the spawn, so abort always
      // outranks an accept on the same channel.
      assign ch_ready[i] = !abort[i] && ((RETRIGGER != 0) || (state_q == ST_IDLE));
      assign accept[i]   = spawn.spawn_valid && spawn.spawn_ready && (spawn.spawn_ch == CHW'(i));

      // Next accumulator value: q tracks floor(|delta|*(k+1)/STEPS) and r the
      // matching remainder. The position moves away from src in the sign of
      // delta, which gives truncation toward zero for negative paths.
      always_comb begin
         sum_h = r_h_q + dr_h_q;
         if (sum_h >= STEPS_R) begin
            r_h_n = sum_h - STEPS_R;
            q_h_n = q_h_q + dq_h_q + HWIDTH'(1);
         end else begin
            r_h_n = sum_h;
            q_h_n = q_h_q + dq_h_q;
         end
         pos_h_n = neg_h_q ? src_h_q - q_h_n : src_h_q + q_h_n;

         sum_v = r_v_q + dr_v_q;
         if (sum_v >= STEPS_R) begin
            r_v_n = sum_v - STEPS_R;
            q_v_n = q_v_q + dq_v_q + VWIDTH'(1);
         end else begin
            r_v_n = sum_v;
            q_v_n = q_v_q + dq_v_q;
         end
         pos_v_n = neg_v_q ? src_v_q - q_v_n : src_v_q + q_v_n;
      end

      // Channel FSM. Priority is abort, then accept, then tick, so a spawn
      // arriving with a tick starts at src and the tick is swallowed.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            src_h_q  <= '0;
            src_v_q  <= '0;
            neg_h_q  <= 1'b0;
            neg_v_q  <= 1'b0;
            dq_h_q   <= '0;
            dq_v_q   <= '0;
            dr_h_q   <= '0;
            dr_v_q   <= '0;
            q_h_q    <= '0;
            q_v_q    <= '0;
            r_h_q    <= '0;
            r_v_q    <= '0;
            off_h_q  <= OFF_H;
            off_v_q  <= OFF_V;
            active_q <= 1'b0;
            done_q   <= 1'b0;
         end else begin
            done_q <= 1'b0;
            if (abort[i]) begin
               state_q  <= ST_IDLE;
               off_h_q  <= OFF_H;
               off_v_q  <= OFF_V;
               active_q <= 1'b0;
            end else if (accept[i]) begin
               state_q  <= ST_MOVE;
               k_q      <= '0;
               src_h_q  <= spawn.src_h;
               src_v_q  <= spawn.src_v;
               neg_h_q  <= neg_h;
               neg_v_q  <= neg_v;
               dq_h_q   <= dq_h;
               dq_v_q   <= dq_v;
               dr_h_q   <= dr_h;
               dr_v_q   <= dr_v;
               q_h_q    <= '0;
               q_v_q    <= '0;
               r_h_q    <= '0;
               r_v_q    <= '0;
               off_h_q  <= spawn.src_h;
               off_v_q  <= spawn.src_v;
               active_q <= 1'b1;
            end else if (tick) begin
               case (state_q)
                  ST_MOVE: begin
                     k_q     <= k_q + KW'(1);
                     q_h_q   <= q_h_n;
                     q_v_q   <= q_v_n;
                     r_h_q   <= r_h_n;
                     r_v_q   <= r_v_n;
                     off_h_q <= pos_h_n;
                     off_v_q <= pos_v_n;
                     // On the final step q equals |delta|, so the offset is dst.
                     if (k_q == LAST_K) begin
                        done_q  <= 1'b1;
                        state_q <= ST_HOLD;
                     end
                  end
                  ST_HOLD: begin
                     state_q  <= ST_IDLE;
                     off_h_q  <= OFF_H;
                     off_v_q  <= OFF_V;
                     active_q <= 1'b0;
                  end
                  default: begin
                  end
               endcase
            end
         end
      end

      assign hoffset[i*HWIDTH +: HWIDTH] = off_h_q;
      assign voffset[i*VWIDTH +: VWIDTH] = off_v_q;
      assign active[i]                   = active_q;
      assign done[i]                     = done_q;
   end

endmodule
